// File: rtl/wb_pkg.sv
// Shared widths, the buffered result record and grant encodings for the
// register-file writeback arbiter.
package wb_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    // One result headed for the register file.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    localparam int WB_ENTRY_W = $bits(wb_entry_t);

    // Which source owns the register-file write port this cycle.
    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_A    = 2'd1;
    localparam logic [1:0] GNT_B    = 2'd2;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering mul/div results. The head is read
// combinationally from the storage array, so an entry written on one edge
// is visible at the head only after that edge (no write-through bypass).
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array: written on accepted pushes only, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally (power-of-two depth); occupancy tracks push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges in-order pipeline results (A) and buffered mul/div results (B)
// into one registered register-file write per cycle, with a starvation
// guard for B and a per-register "owed by B" scoreboard for decode.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [REG_ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0]     a_data,
    output logic                  a_stall,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0]     b_data,
    input  logic                  claim_valid,
    input  logic [REG_ADDR_W-1:0] claim_rd,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_write_reg,
    output logic [DATA_W-1:0]     wb_write_data
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic                  a_live;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [WB_ENTRY_W-1:0] push_word;
    logic [WB_ENTRY_W-1:0] head_word;
    wb_entry_t             head_entry;
    logic [1:0]            grant;
    logic                  starve_hit;
    logic [STARVE_W-1:0]   starve_cnt_reg;
    logic                  head_writes;

    // A request to r0 is swallowed: it neither writes nor stalls.
    assign a_live      = a_valid && (a_rd != '0);
    assign b_ready     = !fifo_full;
    assign fifo_push   = b_valid && b_ready;
    assign push_word   = {b_rd, b_data};
    assign head_entry  = wb_entry_t'(head_word);
    assign starve_hit  = !fifo_empty && (starve_cnt_reg == STARVE_W'(STARVE_LIMIT));
    assign fifo_pop    = (grant == GNT_B);
    assign head_writes = (head_entry.rd != '0);

    wb_fifo #(
        .WIDTH (WB_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (push_word),
        .pop   (fifo_pop),
        .head  (head_word),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Grant selection: starved B first, then live A, then any pending B.
    always_comb begin
        grant = GNT_NONE;
        if (starve_hit) begin
            grant = GNT_B;
        end else if (a_live) begin
            grant = GNT_A;
        end else if (!fifo_empty) begin
            grant = GNT_B;
        end
    end

    // A is held off only when B takes the port while A has real work.
    always_comb begin
        a_stall = (grant == GNT_B) && a_live;
    end

    // Starvation counter: counts consecutive A wins over a waiting B.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_reg <= '0;
        end else if (fifo_empty || (grant == GNT_B)) begin
            starve_cnt_reg <= '0;
        end else if ((grant == GNT_A) && (starve_cnt_reg != STARVE_W'(STARVE_LIMIT))) begin
            starve_cnt_reg <= starve_cnt_reg + STARVE_W'(1);
        end
    end

    // Output registers: load the granted result; hold reg/data otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_reg_write  <= 1'b0;
            wb_write_reg  <= '0;
            wb_write_data <= '0;
        end else if (grant == GNT_A) begin
            wb_reg_write  <= 1'b1;
            wb_write_reg  <= a_rd;
            wb_write_data <= a_data;
        end else if ((grant == GNT_B) && head_writes) begin
            wb_reg_write  <= 1'b1;
            wb_write_reg  <= head_entry.rd;
            wb_write_data <= head_entry.data;
        end else begin
            wb_reg_write  <= 1'b0;
        end
    end

    // r0 is never owed.
    assign busy_mask[0] = 1'b0;

    // Scoreboard bits: a decode claim sets, a B write clears, set wins.
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
        logic bit_set;
        logic bit_clr;
        logic bit_reg;

        assign bit_set      = claim_valid && (claim_rd == REG_ADDR_W'(gi));
        assign bit_clr      = (grant == GNT_B) && (head_entry.rd == REG_ADDR_W'(gi));
        assign busy_mask[gi] = bit_reg;

        // Per-register pending flag.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                bit_reg <= 1'b0;
            end else if (bit_set) begin
                bit_reg <= 1'b1;
            end else if (bit_clr) begin
                bit_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed and randomized checks of the writeback arbiter against a
// queue-based behavioural model.
module tb_writeback_arbiter;
    import wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  a_valid = 1'b0;
    logic [REG_ADDR_W-1:0] a_rd = '0;
    logic [DATA_W-1:0]     a_data = '0;
    logic                  a_stall;
    logic                  b_valid = 1'b0;
    logic                  b_ready;
    logic [REG_ADDR_W-1:0] b_rd = '0;
    logic [DATA_W-1:0]     b_data = '0;
    logic                  claim_valid = 1'b0;
    logic [REG_ADDR_W-1:0] claim_rd = '0;
    logic [NUM_REGS-1:0]   busy_mask;
    logic                  wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_write_reg;
    logic [DATA_W-1:0]     wb_write_data;

    writeback_arbiter #(
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .a_valid       (a_valid),
        .a_rd          (a_rd),
        .a_data        (a_data),
        .a_stall       (a_stall),
        .b_valid       (b_valid),
        .b_ready       (b_ready),
        .b_rd          (b_rd),
        .b_data        (b_data),
        .claim_valid   (claim_valid),
        .claim_rd      (claim_rd),
        .busy_mask     (busy_mask),
        .wb_reg_write  (wb_reg_write),
        .wb_write_reg  (wb_write_reg),
        .wb_write_data (wb_write_data)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Behavioural model state
    wb_entry_t             m_q[$];
    int                    m_wait;   // consecutive A wins while B waits
    logic [NUM_REGS-1:0]   m_busy;
    logic                  m_we;
    logic [REG_ADDR_W-1:0] m_reg;
    logic [DATA_W-1:0]     m_data;
    logic                  last_stall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_wait = 0;
        m_busy = '0;
        m_we   = 1'b0;
        m_reg  = '0;
        m_data = '0;
        last_stall = 1'b0;
    endtask

    // One clock: called just after a negedge with inputs already driven.
    task automatic cycle();
        bit        live, ready, has_b, take_b, take_a;
        wb_entry_t e;
        #1;
        live   = a_valid && (a_rd != 0);
        ready  = (m_q.size() < DEPTH);
        has_b  = (m_q.size() > 0);
        take_b = has_b && ((m_wait == LIMIT) || !live);
        take_a = live && !take_b;
        check("b_ready", 64'(b_ready), 64'(ready));
        check("a_stall", 64'(a_stall), 64'(take_b && live));
        last_stall = take_b && live;
        $display("t=%0t a=%0b/%0d/%h b=%0b/%0d/%h claim=%0b/%0d grant=%s", $time,
                 a_valid, a_rd, a_data, b_valid, b_rd, b_data, claim_valid, claim_rd,
                 take_a ? "A" : (take_b ? "B" : "-"));
        m_we = 1'b0;
        if (take_a) begin
            m_we = 1'b1; m_reg = a_rd; m_data = a_data;
        end else if (take_b) begin
            e = m_q.pop_front();
            if (e.rd != 0) begin
                m_we = 1'b1; m_reg = e.rd; m_data = e.data;
                m_busy[e.rd] = 1'b0;
            end
        end
        if (!has_b || take_b) m_wait = 0;
        else if (take_a && m_wait < LIMIT) m_wait++;
        if (claim_valid && claim_rd != 0) m_busy[claim_rd] = 1'b1;
        if (b_valid && ready) begin
            e.rd = b_rd; e.data = b_data;
            m_q.push_back(e);
        end
        @(posedge clk);
        #1;
        check("wb_reg_write", 64'(wb_reg_write), 64'(m_we));
        check("wb_write_reg", 64'(wb_write_reg), 64'(m_reg));
        check("wb_write_data", 64'(wb_write_data), 64'(m_data));
        check("busy_mask", 64'(busy_mask), 64'(m_busy));
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        a_valid = 0; b_valid = 0; claim_valid = 0;
    endtask

    initial begin
        int waits;
        bit seen;
        model_reset();
        // Reset state
        #2;
        check("rst_wb_reg_write", 64'(wb_reg_write), 64'(0));
        check("rst_busy", 64'(busy_mask), 64'(0));
        check("rst_b_ready", 64'(b_ready), 64'(1));
        check("rst_a_stall", 64'(a_stall), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        cycle();

        // A only
        a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
        cycle();
        check("a_only_data", 64'(wb_write_data), 64'h00000000DEADBEEF);
        check("a_only_reg", 64'(wb_write_reg), 64'd5);
        a_rd = 0; a_data = 32'h123;
        cycle();
        check("a_r0_no_write", 64'(wb_reg_write), 64'd0);
        idle_inputs();

        // B only with scoreboard
        claim_valid = 1; claim_rd = 7;
        cycle();
        claim_valid = 0;
        b_valid = 1; b_rd = 7; b_data = 32'h1234;
        cycle();
        check("b_busy_set", 64'(busy_mask[7]), 64'd1);
        check("b_no_bypass", 64'(wb_reg_write), 64'd0);
        b_valid = 0;
        cycle();
        check("b_write_reg", 64'(wb_write_reg), 64'd7);
        check("b_write_data", 64'(wb_write_data), 64'h1234);
        check("b_busy_clear", 64'(busy_mask[7]), 64'd0);

        // Starvation: one B entry, A live every cycle
        a_valid = 1; a_rd = 9; a_data = 32'hA0000000;
        b_valid = 1; b_rd = 11; b_data = 32'hB0B0;
        cycle();
        b_valid = 0;
        waits = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (!last_stall) a_data = a_data + 1;
            cycle();
            if (last_stall) seen = 1; else waits++;
        end
        check("starve_seen", 64'(seen), 64'd1);
        check("starve_a_wins", 64'(waits), 64'(LIMIT));
        check("starve_b_written", 64'(wb_write_reg), 64'd11);
        cycle();
        check("starve_a_held", 64'(wb_write_data), 64'(a_data));
        idle_inputs();
        cycle();

        // Full FIFO with A blocking B
        a_valid = 1; a_rd = 4;
        for (int i = 0; i < 5; i++) begin
            b_valid = 1; b_rd = 5'(12 + i); b_data = 32'(i + 100); a_data = 32'(i);
            cycle();
        end
        check("full_b_ready", 64'(b_ready), 64'd0);
        idle_inputs();
        cycle();
        check("drain_b_ready", 64'(b_ready), 64'd1);
        for (int i = 0; i < 4; i++) cycle();

        // Set/clear collision on r3
        b_valid = 1; b_rd = 3; b_data = 32'h33;
        cycle();
        b_valid = 0; claim_valid = 1; claim_rd = 3;
        cycle();
        check("collision_set_wins", 64'(busy_mask[3]), 64'd1);
        check("collision_wrote", 64'(wb_write_reg), 64'd3);
        idle_inputs();

        // Randomized traffic, respecting a_stall hold
        for (int i = 0; i < 300; i++) begin
            if (!last_stall) begin
                a_valid = 1'($urandom_range(0, 1));
                a_rd    = 5'($urandom_range(0, 31));
                a_data  = $urandom;
            end
            b_valid     = ($urandom_range(0, 2) == 0);
            b_rd        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            b_data      = $urandom;
            claim_valid = ($urandom_range(0, 3) == 0);
            claim_rd    = 5'($urandom_range(0, 31));
            cycle();
        end

        // Reset mid-stream with buffered entries and claims
        a_valid = 1; a_rd = 2; a_data = 32'h77;
        b_valid = 1; b_rd = 6; b_data = 32'h66; claim_valid = 1; claim_rd = 6;
        cycle();
        cycle();
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("mid_rst_wb_reg_write", 64'(wb_reg_write), 64'd0);
        check("mid_rst_busy", 64'(busy_mask), 64'd0);
        check("mid_rst_b_ready", 64'(b_ready), 64'd1);
        check("mid_rst_a_stall", 64'(a_stall), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
